// File: rtl/frame_stream_ctrl_if.sv
// rtl/frame_stream_ctrl_if.sv - source, generator, kept-output and status signals of frame_stream_ctrl
`timescale 1ns/1ps
interface frame_stream_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  gen_valid_in;
  logic [DATA_WIDTH-1:0] gen_data_in;
  logic                  gen_clr;
  logic                  gen_valid_out;
  logic [DATA_WIDTH-1:0] gen_data_out;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  frame_done;
  logic                  err_short;
  logic                  err_align;
  logic [15:0]           frame_count;

  modport master (
    input  s_valid, s_data, s_last, gen_valid_out, gen_data_out,
    output s_ready, gen_valid_in, gen_data_in, gen_clr,
           m_valid, m_data, m_last, frame_done, err_short, err_align, frame_count
  );

  modport slave (
    output s_valid, s_data, s_last, gen_valid_out, gen_data_out,
    input  s_ready, gen_valid_in, gen_data_in, gen_clr,
           m_valid, m_data, m_last, frame_done, err_short, err_align, frame_count
  );
endinterface

// File: rtl/frame_stream_ctrl.sv
// rtl/frame_stream_ctrl.sv - per-frame sequencer: clear generator, feed pixels, drain and keep outputs
`timescale 1ns/1ps
module frame_stream_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_PIXELS    = 1024,
  parameter int OUT_PIXELS   = 784,
  parameter int DRAIN_CYCLES = 35000,
  parameter int CLR_CYCLES   = 100,
  parameter bit EARLY_EXIT   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  frame_stream_ctrl_if.master bus
);
  localparam int IN_W    = $clog2(IN_PIXELS + 1);
  localparam int OUT_W   = $clog2(OUT_PIXELS + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int CLR_W   = $clog2(CLR_CYCLES + 1);

  typedef enum logic [1:0] {S_CLEAR, S_FEED, S_DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IN_W-1:0]    in_cnt;
  logic [OUT_W-1:0]   out_cnt;
  logic [OUT_W-1:0]   out_cnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CLR_W-1:0]   clr_cnt;
  logic               beat;
  logic               in_last;
  logic               keep;
  logic               clr_done;
  logic               drain_exit;

  always_comb begin
    beat        = bus.s_valid && (state == S_FEED);
    in_last     = (in_cnt == IN_W'(IN_PIXELS - 1));
    keep        = (state != S_CLEAR) && bus.gen_valid_out && (out_cnt < OUT_W'(OUT_PIXELS));
    out_cnt_nxt = out_cnt + OUT_W'(keep);
    clr_done    = (clr_cnt == CLR_W'(CLR_CYCLES - 1));
    // Early exit looks at the registered count, so it lands one cycle after m_last.
    drain_exit  = (state == S_DRAIN) &&
                  ((drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) ||
                   (EARLY_EXIT && (out_cnt == OUT_W'(OUT_PIXELS))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_done)          state_nxt = S_FEED;
      S_FEED:  if (beat && in_last)   state_nxt = S_DRAIN;
      S_DRAIN: if (drain_exit)        state_nxt = S_CLEAR;
      default:                        state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    bus.s_ready = (state == S_FEED);
    bus.gen_clr = (state == S_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      clr_cnt   <= (state == S_CLEAR && !clr_done) ? clr_cnt + 1'b1 : '0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == S_CLEAR) begin
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (beat) in_cnt <= in_cnt + 1'b1;
        out_cnt <= out_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gen_valid_in <= 1'b0;
      bus.gen_data_in  <= '0;
      bus.err_align    <= 1'b0;
      bus.m_valid      <= 1'b0;
      bus.m_data       <= '0;
      bus.m_last       <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.err_short    <= 1'b0;
      bus.frame_count  <= '0;
    end else begin
      bus.gen_valid_in <= beat;
      if (beat) bus.gen_data_in <= bus.s_data;
      // s_last is only checked; frame length always comes from in_cnt.
      bus.err_align    <= beat && (bus.s_last != in_last);
      bus.m_valid      <= keep;
      bus.m_last       <= keep && (out_cnt == OUT_W'(OUT_PIXELS - 1));
      if (keep) bus.m_data <= bus.gen_data_out;
      bus.frame_done   <= drain_exit;
      bus.err_short    <= drain_exit && (out_cnt_nxt < OUT_W'(OUT_PIXELS));
      if (drain_exit) bus.frame_count <= bus.frame_count + 16'd1;
    end
  end
endmodule
